// File: rtl/calc_operand_sequencer.sv
// ============================================================================
// Module   : calc_operand_sequencer
// Purpose  : Operand-entry sequencer and result capture for the 4-bit calculator.
//            Optional macro CALC_OVF_FLAG_EN adds the signed-overflow flag result_ovf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_operand_sequencer #(
   parameter int WIDTH     = 4,
   parameter int DB_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   input  logic             btn_enter,
   input  logic             btn_clear,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             cout_in,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   output logic [WIDTH-1:0] result,
   output logic             result_cout,
   output logic             result_valid,
`ifdef CALC_OVF_FLAG_EN
   output logic             result_ovf,
`endif
   output logic [1:0]       state_o
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_DB_MAX  = CNT_W'(DB_CYCLES);

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_EXEC = 2'b10,
      S_DONE = 2'b11
   } state_t;

   logic [1:0] w_btn_raw;
   logic [1:0] w_btn_pulse;
   logic       w_enter_pulse;
   logic       w_clear_pulse;

   assign w_btn_raw     = {btn_clear, btn_enter};
   assign w_enter_pulse = w_btn_pulse[0];
   assign w_clear_pulse = w_btn_pulse[1];

   // Per button: 2-FF synchronizer, saturating debounce counter, one-shot pulse.
   // The pulse fires once per press because the counter passes DB_CYCLES-1 only once
   // before it saturates, and only a released level resets it.
   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             r_sync1;
      logic             r_sync2;
      logic [CNT_W-1:0] r_cnt;
      logic             r_pulse;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
         end else begin
            r_sync1 <= w_btn_raw[gi];
            r_sync2 <= r_sync1;
            r_pulse <= r_sync2 && (r_cnt == C_DB_LAST);
            if (!r_sync2) begin
               r_cnt <= '0;
            end else if (r_cnt != C_DB_MAX) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end

      assign w_btn_pulse[gi] = r_pulse;
   end

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sub;
   state_t           r_state;
   state_t           w_state_next;
   logic             w_load_a;
   logic             w_load_b;
   logic             w_capture;
   logic             w_clear;

   assign add_a   = r_a;
   assign add_b   = r_sub ? ~r_b : r_b;
   assign add_cin = r_sub;
   assign state_o = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_A;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Clear outranks enter in every state, including the single S_EXEC cycle.
   always_comb begin
      w_state_next = r_state;
      w_load_a     = 1'b0;
      w_load_b     = 1'b0;
      w_capture    = 1'b0;
      w_clear      = 1'b0;
      if (w_clear_pulse) begin
         w_clear      = 1'b1;
         w_state_next = S_A;
      end else begin
         case (r_state)
            S_A: begin
               if (w_enter_pulse) begin
                  w_load_a     = 1'b1;
                  w_state_next = S_B;
               end
            end
            S_B: begin
               if (w_enter_pulse) begin
                  w_load_b     = 1'b1;
                  w_state_next = S_EXEC;
               end
            end
            S_EXEC: begin
               w_capture    = 1'b1;
               w_state_next = S_DONE;
            end
            S_DONE: begin
               if (w_enter_pulse) begin
                  w_load_a     = 1'b1;
                  w_state_next = S_B;
               end
            end
            default: w_state_next = S_A;
         endcase
      end
   end

`ifdef CALC_OVF_FLAG_EN
   logic w_ovf;
   assign w_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum_in[WIDTH-1] != add_a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_ovf <= 1'b0;
      end else if (w_clear || w_load_a) begin
         result_ovf <= 1'b0;
      end else if (w_capture) begin
         result_ovf <= w_ovf;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_sub        <= 1'b0;
         result       <= '0;
         result_cout  <= 1'b0;
         result_valid <= 1'b0;
      end else if (w_clear) begin
         r_a          <= '0;
         r_b          <= '0;
         r_sub        <= 1'b0;
         result       <= '0;
         result_cout  <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         if (w_load_a) begin
            r_a          <= sw_in;
            result_valid <= 1'b0;
         end
         if (w_load_b) begin
            r_b   <= sw_in;
            r_sub <= op_sub;
         end
         if (w_capture) begin
            result       <= sum_in;
            result_cout  <= cout_in;
            result_valid <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire
